// File: rtl/bootram_arbiter.sv
// Arbitrates the four 2Kx8 boot-RAM byte lanes between the CPU word port and the UART loader
// byte port, sequencing each access as grant -> RAM access -> response capture.
module bootram_arbiter #(
  parameter int unsigned AW       = 11,
  parameter bit          WP_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_valid,
  input  logic [AW+1:0] cpu_addr,
  input  logic [3:0]    cpu_wstrb,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  input  logic          ldr_valid,
  input  logic [AW+1:0] ldr_addr,
  input  logic          ldr_we,
  input  logic [7:0]    ldr_wdata,
  output logic [7:0]    ldr_rdata,
  output logic          ldr_ready,
  input  logic          wp_set,
  input  logic          wp_clr,
  output logic          wp,
  output logic [3:0]    ram_ce,
  output logic          ram_oce,
  output logic          ram_wre,
  output logic [AW-1:0] ram_ad,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    ce_q, ce_d;
  logic          wre_q, wre_d;
  logic [AW-1:0] ad_q, ad_d;
  logic [31:0]   din_q, din_d;
  logic          cpu_ready_q, cpu_ready_d;
  logic          ldr_ready_q, ldr_ready_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [7:0]    ldr_rdata_q, ldr_rdata_d;
  logic          wp_q, wp_d;
  logic          last_ldr_q, last_ldr_d;
  logic          gnt_ldr_q, gnt_ldr_d;
  logic [1:0]    lane_q, lane_d;

  logic cpu_req, ldr_req, pick_ldr;

  // Word port ignores the byte offset; lanes are selected by strobes instead.
  logic unused_cpu_addr;
  assign unused_cpu_addr = ^cpu_addr[1:0];

  // A requester whose ready is high this cycle is still holding valid from the finished access.
  assign cpu_req  = cpu_valid & ~cpu_ready_q;
  assign ldr_req  = ldr_valid & ~ldr_ready_q;
  assign pick_ldr = ldr_req & (~cpu_req | ~last_ldr_q);

  always_comb begin
    state_d     = state_q;
    ce_d        = ce_q;
    wre_d       = wre_q;
    ad_d        = ad_q;
    din_d       = din_q;
    cpu_ready_d = 1'b0;
    ldr_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    last_ldr_d  = last_ldr_q;
    gnt_ldr_d   = gnt_ldr_q;
    lane_d      = lane_q;
    wp_d        = wp_clr ? 1'b0 : (wp_set ? 1'b1 : wp_q);

    unique case (state_q)
      StIdle: begin
        ce_d  = 4'b0000;
        wre_d = 1'b0;
        if (cpu_req || ldr_req) begin
          state_d    = StAccess;
          gnt_ldr_d  = pick_ldr;
          last_ldr_d = pick_ldr;
          if (pick_ldr) begin
            ad_d   = ldr_addr[AW+1:2];
            lane_d = ldr_addr[1:0];
            ce_d   = 4'b0001 << ldr_addr[1:0];
            wre_d  = ldr_we;
            din_d  = {4{ldr_wdata}};
          end else begin
            ad_d  = cpu_addr[AW+1:2];
            din_d = cpu_wdata;
            if (cpu_wstrb == 4'b0000) begin
              ce_d  = 4'b1111;
              wre_d = 1'b0;
            end else if (wp_q) begin
              // Protected write: no lane enabled, handshake still completes.
              ce_d  = 4'b0000;
              wre_d = 1'b0;
            end else begin
              ce_d  = cpu_wstrb;
              wre_d = 1'b1;
            end
          end
        end
      end
      StAccess: begin
        ce_d    = 4'b0000;
        wre_d   = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
        if (gnt_ldr_q) begin
          ldr_ready_d = 1'b1;
          ldr_rdata_d = ram_dout[{lane_q, 3'b000} +: 8];
        end else begin
          cpu_ready_d = 1'b1;
          cpu_rdata_d = ram_dout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ce_q        <= 4'b0000;
      wre_q       <= 1'b0;
      ad_q        <= '0;
      din_q       <= '0;
      cpu_ready_q <= 1'b0;
      ldr_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      wp_q        <= WP_RESET;
      last_ldr_q  <= 1'b0;
      gnt_ldr_q   <= 1'b0;
      lane_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      ce_q        <= ce_d;
      wre_q       <= wre_d;
      ad_q        <= ad_d;
      din_q       <= din_d;
      cpu_ready_q <= cpu_ready_d;
      ldr_ready_q <= ldr_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      wp_q        <= wp_d;
      last_ldr_q  <= last_ldr_d;
      gnt_ldr_q   <= gnt_ldr_d;
      lane_q      <= lane_d;
    end
  end

  assign ram_ce    = ce_q;
  assign ram_oce   = 1'b1;
  assign ram_wre   = wre_q;
  assign ram_ad    = ad_q;
  assign ram_din   = din_q;
  assign cpu_ready = cpu_ready_q;
  assign ldr_ready = ldr_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign wp        = wp_q;

endmodule

// File: doc/bootram_arbiter.md
Name: bootram_arbiter

Overview:
- Shares the four 2Kx8 boot-RAM byte lanes (one Gowin SP block per lane, 8 KB total) between the PicoRV32 native memory port and the UART boot-loader byte port.
- Sequences each SP access: address/data/enable registration, a one-cycle RAM access, then response capture.
- Applies an optional write-protect so the boot image behaves as ROM to the CPU.
- Sits between the bus decoder and the bootram lane instances.

Parameters:
- AW, 11, word address width per lane (2K entries).
- WP_RESET, 1, reset value of the internal write-protect flag.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_valid  in  1  CPU request; held until cpu_ready.
- cpu_addr  in  AW+2  CPU byte address; bits [AW+1:2] select the word.
- cpu_wstrb  in  4  byte write strobes; 0 means read.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  CPU read data; valid while cpu_ready is high.
- cpu_ready  out  1  one-cycle completion pulse.
- ldr_valid  in  1  loader request; held until ldr_ready.
- ldr_addr  in  AW+2  loader byte address.
- ldr_we  in  1  loader write (1) or read (0).
- ldr_wdata  in  8  loader write byte.
- ldr_rdata  out  8  loader read byte; valid while ldr_ready is high.
- ldr_ready  out  1  one-cycle completion pulse.
- wp_set  in  1  sets the write-protect flag.
- wp_clr  in  1  clears the write-protect flag.
- wp  out  1  current write-protect flag.
- ram_ce  out  4  per-lane SP CE.
- ram_oce  out  1  SP OCE; constant 1.
- ram_wre  out  1  SP WRE, shared by all lanes.
- ram_ad  out  AW  SP word address, shared by all lanes.
- ram_din  out  32  lane n data on bits [8n+7:8n].
- ram_dout  in  32  lane n data on bits [8n+7:8n].

Behaviour:
- Reset values: state IDLE; ram_ce 0; ram_wre 0; ram_ad 0; ram_din 0; cpu_ready 0; ldr_ready 0; cpu_rdata 0; ldr_rdata 0; wp = WP_RESET; last-grant = CPU.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Exactly one transaction is in flight at a time.

IDLE
- With no valid request, holds ram_ce = 0.
- Arbitration is round-robin when both requesters are valid: grant the requester not granted last. A single valid requester is granted immediately.
- On grant, register ram_ad, ram_wre, ram_din and ram_ce, update last-grant, then go to ACCESS.

CPU grant
- ram_ad = cpu_addr[AW+1:2].
- Read (wstrb = 0): ram_ce = 4'b1111, ram_wre = 0.
- Write: ram_ce = cpu_wstrb, ram_wre = 1, ram_din = cpu_wdata.
- Write while wp = 1: ram_ce = 0 and ram_wre = 0. The RAM is not written, but the handshake still completes normally.

Loader grant
- ram_ad = ldr_addr[AW+1:2].
- Lane L = ldr_addr[1:0]; ram_ce = one-hot(L).
- ram_wre = ldr_we; ram_din = ldr_wdata replicated to all four bytes.
- wp never blocks loader writes.

ACCESS
- The SP samples on this edge.
- Next edge: drop ram_ce and ram_wre to 0, go to RESP.

RESP
- ram_dout is valid (SP READ_MODE 0, one-cycle read latency).
- CPU grant: capture cpu_rdata = ram_dout and pulse cpu_ready for one cycle.
- Loader grant: capture ldr_rdata = ram_dout[8L+7:8L] and pulse ldr_ready for one cycle.
- For writes, the rdata value is don't-care.
- Return to IDLE. A new grant may occur on the next edge, so the minimum transaction period is 3 cycles.

Timing and corner cases
- Latency: valid seen at edge 0 -> ready high in the cycle after edge 2.
- The losing requester waits at most one full transaction.
- Request deasserted before ready: the transaction still completes and the ready pulse is still issued.
- wp_set and wp_clr asserted in the same cycle: wp_clr wins. A wp change during ACCESS does not affect the in-flight access.
- Reset mid-transaction forces IDLE immediately. No ready pulse is issued, and ce/wre drop asynchronously.
- Address bits above AW+1 do not exist. Lane-level address wrap is modulo 2^AW words.

Test Plan:
- Write protect: after reset (wp = 1), CPU write 0xDEADBEEF to 0x0010 with wstrb = F, then read back -> ready pulses on both; read data equals the preloaded image word, not 0xDEADBEEF.
- Full-word write: wp_clr, CPU write 0x11223344 to 0x0010 with wstrb = F, then read -> cpu_rdata = 0x11223344; cpu_ready is high exactly 2 edges after valid for each access.
- Byte strobes: CPU write 0xAABBCCDD to 0x0010 with wstrb = 4'b0100 over prior 0x11223344 -> readback 0x11BB3344; ram_ce was 4'b0100 during ACCESS.
- Loader lane select and wp bypass: with wp = 1, loader writes 0x5A to byte address 0x0013 -> ram_ce = 4'b1000; CPU readback of 0x0010 has byte 3 = 0x5A; loader read of 0x0013 gives ldr_rdata = 0x5A.
- Simultaneous requests: cpu_valid and ldr_valid held continuously -> grants alternate, starting with the loader after reset (last-grant = CPU), one ready pulse every 3 cycles; no requester is starved.
- Reset mid-transaction: assert reset during ACCESS of a CPU write -> ram_ce and ram_wre are 0 immediately, no cpu_ready pulse, FSM is in IDLE and wp = WP_RESET after release.
